// File: rtl/id_pkg.sv
// Shared decode constants, the decoded-field bundle and decode helpers for the
// ID/operand-fetch stage.
package id_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   // Source addresses ride along so a stalled bundle can pick up late writebacks.
   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [11:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } id_fields_t;

   function automatic id_fields_t decode_fields(input logic [31:0] instr);
      id_fields_t f;
      f.opcode = instr[6:0];
      f.funct7 = instr[31:25];
      f.funct3 = instr[14:12];
      f.rd     = instr[11:7];
      f.rs1    = instr[19:15];
      f.rs2    = instr[24:20];
      case (instr[6:0])
         OP_I: begin
            if ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SR)) begin
               f.imm = {7'b0000000, instr[24:20]};
            end else begin
               f.imm = instr[31:20];
            end
         end
         // U-type immediates are truncated to the 12-bit ALU imm port.
         OP_LUI, OP_AUIPC: f.imm = instr[31:20];
         OP_R:             f.imm = 12'h000;
         default:          f.imm = instr[31:20];
      endcase
      return f;
   endfunction

   function automatic logic is_illegal(input logic [6:0] opcode);
      logic ill;
      case (opcode)
         OP_R, OP_I, OP_LUI, OP_AUIPC: ill = 1'b0;
         default:                      ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port,
// entry 0 hardwired to zero, synchronous clear on rst.
module regfile_2r1w
   import id_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] mem_r [NREGS];

   // Storage update: clear on reset, otherwise commit non-x0 writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_r[i] <= {XLEN{1'b0}};
         end
      end else if (we && (waddr != {AW{1'b0}})) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[raddr1];
   assign rdata2 = (raddr2 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[raddr2];

endmodule

// File: rtl/id_regfile_stage.sv
// Decode/operand-fetch stage feeding the ALU through one valid/ready output register.
// Optional macro ID_STAGE_ILLEGAL_TRAP_EN adds out_illegal and zeroes illegal opcodes.
module id_regfile_stage
   import id_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int PC_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [6:0]      out_funct7,
   output logic [2:0]      out_funct3,
   output logic [11:0]     out_imm,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
   output logic            out_illegal,
`endif
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   id_fields_t      fields_s;
   id_fields_t      capture_s;
   id_fields_t      bundle_r;
   logic            valid_r;
   logic [PC_W-1:0] pc_r;
   logic [XLEN-1:0] rs1_val_r;
   logic [XLEN-1:0] rs2_val_r;
   logic [XLEN-1:0] rf_rd1_s;
   logic [XLEN-1:0] rf_rd2_s;
   logic [XLEN-1:0] rs1_fwd_s;
   logic [XLEN-1:0] rs2_fwd_s;
   logic            wb_live_s;
   logic            xfer_s;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
   logic            illegal_s;
   logic            illegal_r;
`endif

   assign fields_s  = decode_fields(in_instr);
   assign in_ready  = !valid_r || out_ready;
   assign xfer_s    = in_valid && in_ready;
   assign wb_live_s = wb_en && (wb_addr != 5'd0);

   regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (fields_s.rs1),
      .raddr2 (fields_s.rs2),
      .rdata1 (rf_rd1_s),
      .rdata2 (rf_rd2_s),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data)
   );

   // Write-first bypass so an operand written this cycle is captured fresh.
   assign rs1_fwd_s = (wb_live_s && (wb_addr == fields_s.rs1)) ? wb_data : rf_rd1_s;
   assign rs2_fwd_s = (wb_live_s && (wb_addr == fields_s.rs2)) ? wb_data : rf_rd2_s;

   // Bundle to capture, with illegal opcodes squashed to zero when trapping is enabled.
   always_comb begin
      capture_s = fields_s;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
      illegal_s = is_illegal(fields_s.opcode);
      if (illegal_s) begin
         capture_s.opcode = 7'd0;
      end else begin
         capture_s.opcode = fields_s.opcode;
      end
`endif
   end

   // Output register: load on transfer, refresh operands while stalled, else drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r   <= 1'b0;
         bundle_r  <= '0;
         pc_r      <= {PC_W{1'b0}};
         rs1_val_r <= {XLEN{1'b0}};
         rs2_val_r <= {XLEN{1'b0}};
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
         illegal_r <= 1'b0;
`endif
      end else if (xfer_s) begin
         valid_r   <= 1'b1;
         bundle_r  <= capture_s;
         pc_r      <= in_pc;
         rs1_val_r <= rs1_fwd_s;
         rs2_val_r <= rs2_fwd_s;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
         illegal_r <= illegal_s;
`endif
      end else if (valid_r && !out_ready) begin
         if (wb_live_s && (wb_addr == bundle_r.rs1)) begin
            rs1_val_r <= wb_data;
         end
         if (wb_live_s && (wb_addr == bundle_r.rs2)) begin
            rs2_val_r <= wb_data;
         end
      end else begin
         valid_r <= 1'b0;
      end
   end

   assign out_valid   = valid_r;
   assign out_opcode  = bundle_r.opcode;
   assign out_funct7  = bundle_r.funct7;
   assign out_funct3  = bundle_r.funct3;
   assign out_imm     = bundle_r.imm;
   assign out_rd      = bundle_r.rd;
   assign out_pc      = pc_r;
   assign out_rs1_val = rs1_val_r;
   assign out_rs2_val = rs2_val_r;
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
   assign out_illegal = illegal_r;
`endif

endmodule

// File: doc/id_regfile_stage.md
Name: id_regfile_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the ALU.
- Accepts one instruction word plus its PC per handshake and splits it into the opcode, funct7, funct3 and imm fields the ALU consumes.
- Reads rs1 and rs2 from an internal 32x32 register file and holds the result in one output pipeline register (valid/ready).
- Accepts ALU results back through a writeback port.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- PC_W, 8, PC width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded bundle valid toward the ALU.
- out_ready  in  1  ALU side consumes the bundle.
- out_opcode  out  7  instr[6:0].
- out_funct7  out  7  instr[31:25].
- out_funct3  out  3  instr[14:12].
- out_imm  out  12  immediate (see Behaviour).
- out_pc  out  PC_W  registered PC.
- out_rd  out  5  instr[11:7].
- out_rs1_val  out  XLEN  operand 1.
- out_rs2_val  out  XLEN  operand 2.
- wb_en  in  1  register write enable.
- wb_addr  in  5  write address.
- wb_data  in  XLEN  write data.

Behaviour:
- Reset: out_valid=0, all bundle outputs 0, every register-file entry 0. in_ready=1 the cycle after rst deasserts. rst mid-handshake drops the held bundle.
- in_ready = !out_valid || out_ready (combinational). A transfer happens when in_valid && in_ready.
- Latency is 1 cycle: a bundle accepted at edge N is presented with out_valid=1 after edge N.
- out_valid clears after an edge where out_ready=1 and no new transfer occurs. Accept and drain in the same cycle keeps out_valid=1 with the new bundle, giving full throughput.
- While out_valid && !out_ready, all out_* are stable.
- Immediate rules:
  - Opcode 0010011 with funct3 001/101 (shifts): imm = {7'b0, instr[24:20]}.
  - Other 0010011: imm = instr[31:20].
  - 0110111/0010111 (LUI/AUIPC): imm = instr[31:20]; this is a truncation imposed by the 12-bit ALU imm port.
  - 0110011 (R-type): imm = 0.
- Register file reads use instr[19:15] and instr[24:20]. Address 0 always reads 0.
- Writeback:
  - A write with wb_en=1 and wb_addr!=0 commits at the edge.
  - A write to x0 is ignored.
- Bypass: if a write and an accepted instruction in the same cycle target the same source register, the captured operand is wb_data (write-first).
- Stall refresh: while a bundle is held (out_valid && !out_ready), a writeback whose address matches the held rs1 or rs2 also updates out_rs1_val / out_rs2_val at that edge. Source addresses are kept internally for this. If both sources match, both update.
- rst has priority over transfer and writeback in the same cycle.

Optional Feature:
- Macro: ID_STAGE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds port out_illegal (out, 1).
  - Any opcode other than 0110011, 0010011, 0110111 or 0010111 sets out_illegal=1 and forces out_opcode=0, so the ALU produces 0.
  - out_illegal resets to 0 and follows the same hold rules as the bundle.
- Undefined: there is no out_illegal port and the opcode passes through unmodified.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_LUI=7'b0110111, OP_AUIPC=7'b0010111;
  - funct3 shift codes F3_SLL=3'b001, F3_SR=3'b101;
  - a decoded-bundle typedef.
- One sub-module, regfile_2r1w: 2 asynchronous read ports, 1 synchronous write port, x0 hardwired to 0, synchronous reset clear. Bypass and stall-refresh logic stay in the top level.

Test Plan:
- Write-then-read: wb x5=0x0000_00AA, then issue 0x00528313 (addi x6,x5,5) -> next cycle out_valid=1, opcode=0010011, funct3=000, imm=0x005, rs1_val=0xAA, rd=6.
- Same-cycle bypass: wb x7=0x1234 in the same cycle as accepting an instruction with rs1=x7 -> rs1_val=0x1234.
- Stall refresh: hold out_ready=0 with a bundle whose rs2=x3, then wb x3=0xFFFF_FFFF -> out_rs2_val becomes 0xFFFF_FFFF next cycle and all other fields are unchanged; release out_ready -> out_valid drops if no new input.
- x0 protection: wb x0=0xDEAD, then read rs1=x0 -> 0. Shift decode 0x40315293 (srai x5,x2,3) -> funct7=0100000, imm=0x003.
- Backpressure/throughput: a stream of 4 back-to-back instructions with out_ready=1 gives 4 consecutive valid cycles. out_ready=0 -> in_ready=0 and the bundle is held.
- Reset mid-stall: rst while out_valid=1 -> out_valid=0 and registers read 0. With ID_STAGE_ILLEGAL_TRAP_EN defined, opcode 1111111 -> out_illegal=1 and out_opcode=0.
